// File: rtl/adder_pipe_responder.sv
// rtl/adder_pipe_responder.sv - 2-stage adder pipeline feeding a result FIFO, read back on access_type READ
// Optional carry-out storage and carry_o port are enabled by defining ADDER_CARRY_OUT_EN.
module adder_pipe_responder #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [DATA_WIDTH-1:0]           a,
  input  logic [DATA_WIDTH-1:0]           b,
  input  logic [1:0]                      access_type,
  output logic [DATA_WIDTH-1:0]           o,
  output logic                            o_valid,
  output logic                            full,
  output logic                            empty,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] count,
`ifdef ADDER_CARRY_OUT_EN
  output logic                            carry_o,
`endif
  output logic                            wr_err,
  output logic                            rd_err
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int OW = CW + 1;
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
`ifdef ADDER_CARRY_OUT_EN
  localparam int EW = DATA_WIDTH + 1;
`else
  localparam int EW = DATA_WIDTH;
`endif

  logic [DATA_WIDTH-1:0] r_s1_a;
  logic [DATA_WIDTH-1:0] r_s1_b;
  logic                  r_s1_valid;
  logic [EW-1:0]         r_s2_sum;
  logic                  r_s2_valid;
  logic [EW-1:0]         r_mem [FIFO_DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;

  logic          w_is_write;
  logic          w_is_read;
  logic          w_is_flush;
  logic [OW-1:0] w_occ;
  logic          w_wr_acc;
  logic          w_push;
  logic          w_pop;
  logic [CW-1:0] w_count_nxt;
  logic          w_s1_nxt;
  logic          w_s2_nxt;
  logic [OW-1:0] w_occ_nxt;
  logic [EW-1:0] w_head;
  logic [EW-1:0] w_sum;

  // X or undefined encodings fall through to the default arm and behave as NOP
  always_comb begin
    w_is_write = 1'b0;
    w_is_read  = 1'b0;
    w_is_flush = 1'b0;
    case (access_type)
      2'b01:   w_is_write = 1'b1;
      2'b10:   w_is_read  = 1'b1;
      2'b11:   w_is_flush = 1'b1;
      default: ;
    endcase
  end

  // Occupancy counts in-flight pipeline entries so the FIFO can never overflow on push
  always_comb begin
    w_occ       = OW'(count) + OW'(r_s1_valid) + OW'(r_s2_valid);
    w_wr_acc    = w_is_write && (w_occ < OW'(FIFO_DEPTH));
    w_push      = r_s2_valid && !w_is_flush;
    w_pop       = w_is_read && (count != '0);
    w_s1_nxt    = w_wr_acc;
    w_s2_nxt    = r_s1_valid && !w_is_flush;
    w_count_nxt = w_is_flush ? '0 : (count + CW'(w_push) - CW'(w_pop));
    w_occ_nxt   = OW'(w_count_nxt) + OW'(w_s1_nxt) + OW'(w_s2_nxt);
    w_head      = r_mem[r_rd_ptr];
  end

`ifdef ADDER_CARRY_OUT_EN
  assign w_sum = {1'b0, r_s1_a} + {1'b0, r_s1_b};
`else
  assign w_sum = r_s1_a + r_s1_b;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_valid <= 1'b0;
      r_s2_sum   <= '0;
      r_s2_valid <= 1'b0;
    end else begin
      r_s1_valid <= w_s1_nxt;
      r_s2_valid <= w_s2_nxt;
      if (w_wr_acc) begin
        r_s1_a <= a;
        r_s1_b <= b;
      end
      if (r_s1_valid) begin
        r_s2_sum <= w_sum;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= r_s2_sum;
    end
  end

  // Pointers are AW bits wide, so wrap modulo FIFO_DEPTH is implicit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      count    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
    end else begin
      if (w_is_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      count <= w_count_nxt;
      full  <= (w_occ_nxt == OW'(FIFO_DEPTH));
      empty <= (w_count_nxt == '0);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o       <= '0;
      o_valid <= 1'b0;
      wr_err  <= 1'b0;
      rd_err  <= 1'b0;
`ifdef ADDER_CARRY_OUT_EN
      carry_o <= 1'b0;
`endif
    end else begin
      o_valid <= w_pop;
      wr_err  <= w_is_write && !w_wr_acc;
      rd_err  <= w_is_read && !w_pop;
      if (w_pop) begin
        o <= w_head[DATA_WIDTH-1:0];
`ifdef ADDER_CARRY_OUT_EN
        carry_o <= w_head[DATA_WIDTH];
`endif
      end
    end
  end

endmodule

// File: tb/tb_adder_pipe_responder.sv
// tb/tb_adder_pipe_responder.sv - directed scoreboard bench for adder_pipe_responder
// Build with ADDER_CARRY_OUT_EN defined to also check carry_o.
module tb_adder_pipe_responder;

  localparam int DW = 8;
  localparam int D  = 4;
  localparam int CW = 3;

  localparam logic [1:0] NOP = 2'b00;
  localparam logic [1:0] WR  = 2'b01;
  localparam logic [1:0] RD  = 2'b10;
  localparam logic [1:0] FL  = 2'b11;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] a;
  logic [DW-1:0] b;
  logic [1:0]    access_type;
  logic [DW-1:0] o;
  logic          o_valid;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic          wr_err;
  logic          rd_err;
`ifdef ADDER_CARRY_OUT_EN
  logic          carry_o;
`endif

  logic [DW:0] exp_q [$];
  int n_vec  = 0;
  int n_fail = 0;
  int n_wr_err = 0;
  int n_rd_err = 0;
  int wr_snap;
  int rd_snap;

  always #5 clk = ~clk;

  adder_pipe_responder #(.DATA_WIDTH(DW), .FIFO_DEPTH(D)) dut (
    .clk(clk),
    .rst(rst),
    .a(a),
    .b(b),
    .access_type(access_type),
    .o(o),
    .o_valid(o_valid),
    .full(full),
    .empty(empty),
    .count(count),
`ifdef ADDER_CARRY_OUT_EN
    .carry_o(carry_o),
`endif
    .wr_err(wr_err),
    .rd_err(rd_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic op(input logic [1:0] t, input logic [DW-1:0] aa, input logic [DW-1:0] bb);
    access_type = t;
    a = aa;
    b = bb;
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [DW:0] e);
    exp_q.push_back(e);
    op(RD, 8'd0, 8'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_o"}, o, 0);
    chk({tag, "_o_valid"}, o_valid, 0);
    chk({tag, "_full"}, full, 0);
    chk({tag, "_empty"}, empty, 1);
    chk({tag, "_count"}, count, 0);
    chk({tag, "_wr_err"}, wr_err, 0);
    chk({tag, "_rd_err"}, rd_err, 0);
  endtask

  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (wr_err) n_wr_err++;
      if (rd_err) n_rd_err++;
      if (o_valid) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("FAIL unexpected_o_valid: got o=%0d expected no output", o);
        end else begin
          logic [DW:0] e;
          e = exp_q.pop_front();
          chk("o_data", o, e[DW-1:0]);
`ifdef ADDER_CARRY_OUT_EN
          chk("carry_o", carry_o, e[DW]);
`endif
        end
      end
    end
  end

  initial begin
    rst = 1'b0;
    access_type = NOP;
    a = '0;
    b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("rst");
    rst = 1'b1;

    // read while empty
    op(RD, 8'd0, 8'd0);
    chk("empty_rd_err", rd_err, 1);
    chk("empty_rd_o", o, 0);
    chk("empty_rd_o_valid", o_valid, 0);
    chk("empty_rd_count", count, 0);
    op(NOP, 8'd0, 8'd0);
    chk("empty_rd_err_pulse", rd_err, 0);
    chk("empty_rd_err_cnt", n_rd_err, 1);

    // single op 3+5
    op(WR, 8'd3, 8'd5);
    chk("t1_count_e0", count, 0);
    chk("t1_empty_e0", empty, 1);
    op(NOP, 8'd0, 8'd0);
    op(NOP, 8'd0, 8'd0);
    chk("t1_count_e2", count, 1);
    chk("t1_empty_e2", empty, 0);
    rd(9'h008);
    chk("t1_o_valid", o_valid, 1);
    chk("t1_count_after_rd", count, 0);
    op(NOP, 8'd0, 8'd0);
    chk("t1_o_valid_pulse", o_valid, 0);
    chk("t1_o_hold", o, 8);

    // wrap-around 0xFF + 0x02
    op(WR, 8'hFF, 8'h02);
    op(NOP, 8'd0, 8'd0);
    op(NOP, 8'd0, 8'd0);
    rd(9'h101);
    op(NOP, 8'd0, 8'd0);

    // fill to full, overflow write, drain
    op(WR, 8'd1, 8'd1);
    op(WR, 8'd2, 8'd2);
    op(WR, 8'd3, 8'd3);
    chk("t3_full_3w", full, 0);
    op(WR, 8'd4, 8'd4);
    chk("t3_full_4w", full, 1);
    op(WR, 8'd9, 8'd9);
    chk("t3_wr_err", wr_err, 1);
    chk("t3_full_5w", full, 1);
    op(NOP, 8'd0, 8'd0);
    chk("t3_wr_err_pulse", wr_err, 0);
    chk("t3_count_4", count, 4);
    chk("t3_wr_err_cnt", n_wr_err, 1);
    rd(9'd2);
    chk("t3_full_after_rd", full, 0);
    rd(9'd4);
    rd(9'd6);
    rd(9'd8);
    chk("t3_empty", empty, 1);
    chk("t3_count_0", count, 0);

    // pointer wrap with simultaneous push and pop
    op(NOP, 8'd0, 8'd0);
    wr_snap = n_wr_err;
    rd_snap = n_rd_err;
    op(WR, 8'd1, 8'd1);
    op(NOP, 8'd0, 8'd0);
    op(NOP, 8'd0, 8'd0);
    for (int g = 0; g < 4; g++) begin
      op(WR, 8'(2*g+2), 8'(2*g+2));
      chk("t5_count_le2", (count <= 2), 1);
      op(WR, 8'(2*g+3), 8'(2*g+3));
      chk("t5_count_le2", (count <= 2), 1);
      rd(9'(2*(2*g+1)));
      chk("t5_count_le2", (count <= 2), 1);
      rd(9'(2*(2*g+2)));
      chk("t5_count_le2", (count <= 2), 1);
    end
    op(WR, 8'd10, 8'd10);
    op(NOP, 8'd0, 8'd0);
    op(NOP, 8'd0, 8'd0);
    chk("t5_count_2", count, 2);
    rd(9'd18);
    rd(9'd20);
    op(NOP, 8'd0, 8'd0);
    chk("t5_no_wr_err", n_wr_err - wr_snap, 0);
    chk("t5_no_rd_err", n_rd_err - rd_snap, 0);

    // flush with results in flight
    op(WR, 8'd5, 8'd5);
    op(WR, 8'd6, 8'd6);
    op(FL, 8'd0, 8'd0);
    chk("t6_flush_count", count, 0);
    chk("t6_flush_empty", empty, 1);
    chk("t6_flush_full", full, 0);
    chk("t6_flush_o_hold", o, 20);
    chk("t6_flush_no_rd_err", rd_err, 0);
    op(NOP, 8'd0, 8'd0);
    op(NOP, 8'd0, 8'd0);
    chk("t6_flush_lost", count, 0);

    // asynchronous reset mid-operation
    op(WR, 8'd7, 8'd7);
    rst = 1'b0;
    #1;
    chk_reset_vals("midrst");
    @(posedge clk);
    #1;
    rst = 1'b1;
    op(NOP, 8'd0, 8'd0);
    op(NOP, 8'd0, 8'd0);
    chk("t6_post_rst_count", count, 0);
    op(RD, 8'd0, 8'd0);
    chk("t6_post_rst_rd_err", rd_err, 1);
    chk("t6_post_rst_o", o, 0);
    op(NOP, 8'd0, 8'd0);
    op(NOP, 8'd0, 8'd0);

    chk("exp_q_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/adder_pipe_responder.md
Name: adder_pipe_responder

Overview:
DUT-side responder for the adder access protocol: samples operand pairs a/b and access_type on each clk edge, computes sums in a 2-stage pipeline, queues results in a small FIFO, and returns them on o when read. It sits at the DUT end of adder_interface, opposite the driver clocking block. It adds handshake status (valid/full/empty/error) so the bench can check it cycle-accurately.

Parameters:
DATA_WIDTH, ADDER_DATA_WIDTH (parameters_pkg), operand and result width
FIFO_DEPTH, 4, result queue entries; power of two, >=2

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous active-low reset
a  input  DATA_WIDTH  operand A, sampled when access_type==WRITE
b  input  DATA_WIDTH  operand B, sampled when access_type==WRITE
access_type  input  2  00 NOP, 01 WRITE, 10 READ, 11 FLUSH
o  output  DATA_WIDTH  registered result returned by READ
o_valid  output  1  one-cycle pulse: o updated by an accepted READ
full  output  1  occupancy == FIFO_DEPTH
empty  output  1  FIFO count == 0
count  output  $clog2(FIFO_DEPTH+1)  results currently in FIFO, readable
wr_err  output  1  one-cycle pulse: WRITE dropped due to full
rd_err  output  1  one-cycle pulse: READ while empty

Behaviour:
- Reset (rst low, async): o=0, o_valid=0, full=0, empty=1, count=0, wr_err=0, rd_err=0; pipeline valids and FIFO pointers cleared. Release is synchronous to clk.
- Arithmetic: sum = a + b modulo 2^DATA_WIDTH. Carry is discarded unless the optional feature is enabled.
- Occupancy = count + in-flight pipeline entries (stage1 valid + stage2 valid).
- WRITE accepted when occupancy < FIFO_DEPTH. Pipeline timing:
  - Edge N: a,b captured into stage1.
  - Edge N+1: sum registered in stage2.
  - Edge N+2: pushed to FIFO.
  - count/empty reflect the entry after edge N+2.
  - full reflects occupancy, so it rises after edge N.
- WRITE when occupancy == FIFO_DEPTH: operands dropped, wr_err=1 for one cycle after edge N, no state change.
- READ with count>0: head popped at edge N, o=head value and o_valid=1 during cycle N+1, o_valid low afterwards.
- READ with count==0: rd_err=1 for one cycle, o holds its last value, o_valid=0. A result still in the pipeline is not forwarded.
- Push and pop in the same edge (stage2 push + READ): both occur, count unchanged, FIFO order preserved.
- Results are strictly FIFO ordered. Pointers wrap modulo FIFO_DEPTH.
- FLUSH: clears FIFO, stage1 and stage2 valids at the edge. count=0, empty=1, full=0. o holds, no error pulses. In-flight sums are lost.
- NOP: no state change except the pipeline advancing.
- Unknown/X access_type is treated as NOP (verification asserts it never occurs after reset).
- All outputs are registered, with no combinational path from inputs to outputs.
- Reset asserted mid-operation: immediate clear to reset values regardless of pipeline or FIFO contents.

Optional Feature:
ADDER_CARRY_OUT_EN
- Defined: adds output port carry_o (1 bit). Each FIFO entry stores DATA_WIDTH+1 bits. carry_o is the carry of the popped sum, updated with o and o_valid. Reset value 0; carry_o holds on rd_err/FLUSH.
- Undefined: carry_o port absent, entries are DATA_WIDTH bits, carry discarded.

Test Plan:
1. Reset then single op: WRITE a=3,b=5, NOP x2, READ -> count=1 after 3rd edge, o=8 with o_valid=1 one cycle after READ, count back to 0.
2. Wrap-around arithmetic (DATA_WIDTH=8): WRITE a=0xFF,b=0x02, NOP x2, READ -> o=0x01; with ADDER_CARRY_OUT_EN defined, carry_o=1.
3. Fill to full (DEPTH=4): WRITE 1+1, 2+2, 3+3, 4+4 back-to-back, then WRITE 9+9 -> full=1 after 4th write edge, wr_err pulse on 5th. 4 READs after draining return 2,4,6,8 in order, then empty=1.
4. Read when empty: READ immediately after reset -> rd_err=1 one cycle, o=0, o_valid=0, count=0.
5. Pointer wrap and simultaneous push/pop: alternate WRITE/READ for 10 ops, operands i+i for i=1..10. Every accepted READ after the pipe fills returns 2i in order, count never exceeds 2, no err pulses.
6. FLUSH and mid-op reset: 2 WRITEs, FLUSH during pipeline -> count=0, empty=1, o unchanged. Then WRITE 7+7, assert rst for 1 cycle at the next edge -> all outputs return to reset values, and a subsequent READ gives rd_err=1.
